ntt_butterfly_unit: RTL and testbench

- Parametrised, fully pipelined radix-2 NTT butterfly with a valid/ready stream interface.
- Executes Cooley-Tukey (DIT), Gentleman-Sande (DIF), multiply-only or bypass operations, selectable per operand pair.
- Carries a user tag alongside each operation.
- Sits between the coefficient memory read path and the write-back path of the NTT core; one operation accepted per cycle when not stalled.

---
 rtl/ntt_butterfly_unit.sv | 203 ++++++++++++++++++++
 tb/tb_ntt_butterfly_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_unit.sv
// ntt_butterfly_unit
//   Fully pipelined radix-2 NTT butterfly (DIT / DIF / MUL / BYPASS per operation)
//   with a valid/ready stream interface and a sideband tag. Latency is
//   MUL_STAGES+1 cycles for every mode, and one operation can be accepted per cycle.
//
//   Datapath order (one physical modular multiplier):
//     s0 register : DIF pre-add/sub, or pass-through operands for other modes
//     multiplier  : combinational product/reduction of s0, then MUL_STAGES-1 delay regs
//     output reg  : DIT post-add/sub, or mode-dependent selection
//   Because the pre-add and the post-add sit at fixed slots around the multiplier,
//   every mode uses the multiplier in the same slot. Modes can therefore interleave
//   without any structural hazard.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           input handshake (in_ready = pipeline advance)
//   in_mode, in_a, in_b, in_w   operation and operands (operands < modulus)
//   in_tag                      sideband tag carried alongside the operation
//   modulus                     q, odd, quasi-static (only changed while busy=0)
//   out_valid/out_ready         output handshake
//   out_a, out_b, out_tag       results and echoed tag
//   busy                        any stage holds a valid operation
module ntt_butterfly_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        MODE_DIT = 2'd0,
        MODE_DIF = 2'd1,
        MODE_MUL = 2'd2,
        MODE_BYP = 2'd3
    } mode_e;

    // Entry leaving the multiplier: a = operand carried alongside, p = reduced product
    typedef struct packed {
        logic             v;
        mode_e            mode;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] p;
    } mid_t;

    logic             adv;
    logic [WIDTH:0]   q_ext;

    logic [WIDTH:0]   pre_sum, pre_diff;
    logic [WIDTH-1:0] pre_s, pre_d;

    logic             s0_v_q, s0_v_d;
    mode_e            s0_mode_q, s0_mode_d;
    logic [TAG_W-1:0] s0_tag_q, s0_tag_d;
    logic [WIDTH-1:0] s0_a_q, s0_a_d;
    logic [WIDTH-1:0] s0_x_q, s0_x_d;
    logic [WIDTH-1:0] s0_w_q, s0_w_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   p_red;
    mid_t               head, tail;
    logic               dly_busy;

    logic [WIDTH:0]   post_sum, post_diff;
    logic [WIDTH-1:0] out_a_d, out_b_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_a_q, out_b_q;
    logic [TAG_W-1:0] out_tag_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign q_ext    = {1'b0, modulus};

    // Pre-add/sub (DIF). Bit WIDTH of the difference is the borrow.
    assign pre_sum  = {1'b0, in_a} + {1'b0, in_b};
    assign pre_diff = {1'b0, in_a} - {1'b0, in_b};
    assign pre_s    = WIDTH'((pre_sum >= q_ext) ? (pre_sum - q_ext) : pre_sum);
    assign pre_d    = WIDTH'(pre_diff[WIDTH] ? (pre_diff + q_ext) : pre_diff);

    always_comb begin
        s0_v_d    = in_valid;
        s0_mode_d = mode_e'(in_mode);
        s0_tag_d  = in_tag;
        s0_a_d    = in_a;
        s0_x_d    = in_b;
        s0_w_d    = in_w;
        case (mode_e'(in_mode))
            MODE_DIF: begin
                s0_a_d = pre_s;
                s0_x_d = pre_d;
            end
            MODE_MUL: s0_a_d = '0;
            // W=1 lets B pass through the multiplier unchanged (B < q)
            MODE_BYP: s0_w_d = WIDTH'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_v_q    <= 1'b0;
            s0_mode_q <= MODE_DIT;
            s0_tag_q  <= '0;
            s0_a_q    <= '0;
            s0_x_q    <= '0;
            s0_w_q    <= '0;
        end else if (adv) begin
            s0_v_q    <= s0_v_d;
            s0_mode_q <= s0_mode_d;
            s0_tag_q  <= s0_tag_d;
            s0_a_q    <= s0_a_d;
            s0_x_q    <= s0_x_d;
            s0_w_q    <= s0_w_d;
        end
    end

    // Single modular multiplier; the delay registers behind it leave room for retiming
    assign prod  = {{WIDTH{1'b0}}, s0_x_q} * {{WIDTH{1'b0}}, s0_w_q};
    assign p_red = WIDTH'(prod % {{WIDTH{1'b0}}, modulus});
    assign head  = {s0_v_q, s0_mode_q, s0_tag_q, s0_a_q, p_red};

    generate
        if (MUL_STAGES > 1) begin : g_dly
            mid_t                  dly_q [MUL_STAGES-1];
            logic [MUL_STAGES-2:0] dly_v;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < MUL_STAGES-1; k++) dly_q[k] <= '0;
                end else if (adv) begin
                    dly_q[0] <= head;
                    for (int k = 1; k < MUL_STAGES-1; k++) dly_q[k] <= dly_q[k-1];
                end
            end

            always_comb begin
                dly_v = '0;
                for (int k = 0; k < MUL_STAGES-1; k++) dly_v[k] = dly_q[k].v;
            end

            assign tail     = dly_q[MUL_STAGES-2];
            assign dly_busy = |dly_v;
        end else begin : g_nodly
            assign tail     = head;
            assign dly_busy = 1'b0;
        end
    endgenerate

    // Post-add/sub (DIT)
    assign post_sum  = {1'b0, tail.a} + {1'b0, tail.p};
    assign post_diff = {1'b0, tail.a} - {1'b0, tail.p};

    always_comb begin
        out_a_d = tail.a;
        out_b_d = tail.p;
        case (tail.mode)
            MODE_DIT: begin
                out_a_d = WIDTH'((post_sum >= q_ext) ? (post_sum - q_ext) : post_sum);
                out_b_d = WIDTH'(post_diff[WIDTH] ? (post_diff + q_ext) : post_diff);
            end
            MODE_MUL: out_a_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= tail.v;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_tag_q   <= tail.tag;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_tag   = out_tag_q;
    assign busy      = s0_v_q || dly_busy || out_valid_q;

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
module tb_ntt_butterfly_unit;

    localparam int WIDTH      = 32;
    localparam int MUL_STAGES = 3;
    localparam int TAG_W      = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_a, in_b, in_w;
    logic [TAG_W-1:0] in_tag;
    logic [WIDTH-1:0] modulus;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a, out_b;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    ntt_butterfly_unit #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
        .modulus(modulus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   rand_rdy    = 0;

    bit               stalled = 0;
    logic [WIDTH-1:0] hold_a, hold_b;
    logic [TAG_W-1:0] hold_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [31:0] a, b, w, q,
                                   input logic [7:0] tag);
        longint unsigned av = a, bv = b, wv = w, qv = q, p, s, d;
        exp_t e;
        e.tag = tag;
        case (m)
            2'd0: begin
                p   = (bv * wv) % qv;
                e.a = 32'((av + p) % qv);
                e.b = 32'((av + qv - p) % qv);
            end
            2'd1: begin
                s   = (av + bv) % qv;
                d   = (av + qv - bv) % qv;
                e.a = 32'(s);
                e.b = 32'((d * wv) % qv);
            end
            2'd2: begin
                e.a = '0;
                e.b = 32'((bv * wv) % qv);
            end
            default: begin
                e.a = a;
                e.b = b;
            end
        endcase
        return e;
    endfunction

    // Scoreboard push on acceptance, pop/compare on output handshake, stall stability
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_a", out_a, hold_a);
                chk("stall_hold_b", out_b, hold_b);
                chk("stall_hold_tag", out_tag, hold_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_tag", out_tag, e.tag);
                    chk("range_a", out_a < modulus, 1);
                    chk("range_b", out_b < modulus, 1);
                end
            end
            stalled  = out_valid && !out_ready;
            hold_a   = out_a;
            hold_b   = out_b;
            hold_tag = out_tag;
            if (in_valid && in_ready)
                sb.push_back(model(in_mode, in_a, in_b, in_w, modulus, in_tag));
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic send(input logic [1:0] m, input logic [31:0] a, b, w, input logic [7:0] tag);
        bit acc;
        int n = 0;
        in_valid = 1; in_mode = m; in_a = a; in_b = b; in_w = w; in_tag = tag;
        forever begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", acc, 1);
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] pick(input logic [31:0] q);
        int unsigned r = $urandom_range(0, 7);
        if (r == 0) return 32'd0;
        if (r == 1) return q - 32'd1;
        return $urandom % q;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; in_valid = 0; in_mode = 0; in_a = 0; in_b = 0; in_w = 0; in_tag = 0;
        modulus = 32'd17; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // DIT latency and value: A=5 B=3 W=4, q=17 -> (0,10)
        send(2'd0, 5, 3, 4, 8'hA5);
        repeat (MUL_STAGES) begin
            @(negedge clk);
            chk("lat_early_valid", out_valid, 0);
        end
        @(negedge clk);
        chk("lat_on_time_valid", out_valid, 1);
        chk("dit_out_a", out_a, 0);
        chk("dit_out_b", out_b, 10);
        chk("dit_out_tag", out_tag, 8'hA5);
        @(posedge clk); #1;
        drain();

        // DIF: (5,3,4) -> (8,8); (16,16,1) -> (15,0)
        send(2'd1, 5, 3, 4, 8'h11);
        send(2'd1, 16, 16, 1, 8'h12);
        drain();

        // Back-to-back mixed stream, tags 0..7
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 2) send(2'd2, 7, 16, 16, 8'(i));
            else            send(2'(i % 4), 32'(i + 3), 32'(16 - i), 32'(i * 2 + 1), 8'(i));
        end
        repeat (4) begin
            @(negedge clk);
            chk("stream_continuous", out_valid, 1);
        end
        @(negedge clk);
        chk("stream_end", out_valid, 0);
        @(posedge clk); #1;
        drain();

        // Downstream stall of 5 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(2'(i % 4), 32'(i + 9), 32'(i), 32'(15 - i), 8'(8'h40 + i));
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        drain();

        // Reset discards in-flight work and wins over a simultaneous acceptance
        send(2'd0, 1, 2, 3, 8'hE1);
        send(2'd1, 4, 5, 6, 8'hE2);
        send(2'd3, 7, 8, 9, 8'hE3);
        reset = 1;
        in_valid = 1; in_mode = 2'd3; in_a = 3; in_b = 4; in_w = 5; in_tag = 8'hEE;
        @(posedge clk); #1;
        reset = 0; in_valid = 0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_a", out_a, 0);
        chk("midrst_out_b", out_b, 0);
        chk("midrst_out_tag", out_tag, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        idle(10);
        chk("midrst_idle_busy", busy, 0);

        // Random traffic with a large modulus
        modulus = 32'hFFFF_FFFB;
        rand_rdy = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(2'($urandom_range(0, 3)), pick(modulus), pick(modulus), pick(modulus),
                 8'($urandom));
        end
        rand_rdy = 0;
        out_ready = 1;
        drain();
        idle(2);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
